// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: sequences one ifmap row through a 3-tap PE and streams back its valid partial sums.
// Optional feature: define PE_SEQ_STALL_CNT_EN to add the stall_cnt[15:0] output.
module pe_seq_ctrl #(
  parameter int ROW_LEN  = 32,
  parameter int PIPE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] filt_cfg,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_data,
  output logic        pe_en,
  output logic [7:0]  pe_ifmap,
  output logic [11:0] pe_filt,
  input  logic [13:0] pe_psum,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [13:0] res_data,
  output logic        busy,
  output logic        done
`ifdef PE_SEQ_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  localparam int D  = 2 + PIPE_LAT;
  localparam int CW = $clog2(ROW_LEN + 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t          r_state;
  logic            r_busy;
  logic            r_done;
  logic [11:0]     r_filt;
  logic [CW-1:0]   r_pix_cnt;
  logic [CW-1:0]   r_res_cnt;
  logic [D-1:0]    r_tag;
  logic            r_res_valid;
  logic [13:0]     r_res_data;
  logic            w_run;
  logic            w_drain;
  logic            w_stall;
  logic            w_accept;
  logic            w_pe_en;
  logic            w_capture;
  logic            w_res_acc;
  logic            w_last_pix;
  logic            w_last_res;
  // A pending result that cannot leave blocks any PE advance that would overwrite it.
  assign w_run      = r_state == S_RUN;
  assign w_drain    = r_state == S_DRAIN;
  assign w_stall    = r_tag[D-1] && r_res_valid && !res_ready;
  assign w_accept   = w_run && pix_valid && !w_stall;
  assign w_pe_en    = w_accept || (w_drain && !w_stall && |r_tag);
  assign w_capture  = r_tag[D-1] && w_pe_en && (!r_res_valid || res_ready);
  assign w_res_acc  = r_res_valid && res_ready;
  assign w_last_pix = w_accept && r_pix_cnt == CW'(ROW_LEN - 1);
  assign w_last_res = w_res_acc && r_res_cnt == CW'(ROW_LEN - 3);
  assign pix_ready  = w_run && !w_stall;
  assign pe_en      = w_pe_en;
  assign pe_ifmap   = w_accept ? pix_data : 8'd0;
  assign pe_filt    = r_filt;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign busy       = r_busy;
  assign done       = r_done;
  // Row sequencer with registered busy/done and filter latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_filt  <= 12'd0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_LOAD;
          r_busy  <= 1'b1;
        end
        S_LOAD: begin
          r_state <= S_RUN;
          r_filt  <= filt_cfg;
        end
        S_RUN: if (w_last_pix) r_state <= S_DRAIN;
        S_DRAIN: if (w_last_res) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // Tag pipeline marks which PE outputs are full 3-pixel windows; counters and result register.
  always_ff @(posedge clk) begin
    if (!rst_n || r_state == S_LOAD) begin
      r_tag       <= '0;
      r_pix_cnt   <= '0;
      r_res_cnt   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= 14'd0;
    end else begin
      if (w_pe_en) r_tag <= {r_tag[D-2:0], w_accept && r_pix_cnt >= CW'(2)};
      r_pix_cnt <= (w_accept && r_pix_cnt != CW'(ROW_LEN)) ? r_pix_cnt + CW'(1) : r_pix_cnt;
      r_res_cnt <= w_res_acc ? r_res_cnt + CW'(1) : r_res_cnt;
      r_res_valid <= w_capture ? 1'b1 : w_res_acc ? 1'b0 : r_res_valid;
      r_res_data  <= w_capture ? pe_psum : r_res_data;
    end
  end
`ifdef PE_SEQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  assign stall_cnt = r_stall_cnt;
  // Saturating count of cycles lost to back-pressure or input starvation.
  always_ff @(posedge clk) begin
    if (!rst_n || r_state == S_LOAD) r_stall_cnt <= 16'd0;
    else if (r_busy && (w_stall || (w_run && !pix_valid)) && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: scoreboard bench for pe_seq_ctrl with a behavioural 3-tap PE.
module tb_pe_seq_ctrl;
  localparam int R = 8;
  localparam int L = 1;
  localparam int D = 2 + L;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] filt_cfg = 12'd0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  pix_data = 8'd0;
  logic        pe_en;
  logic [7:0]  pe_ifmap;
  logic [11:0] pe_filt;
  logic [13:0] pe_psum;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [13:0] res_data;
  logic        busy;
  logic        done;
`ifdef PE_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int errors = 0;
  int checks = 0;
  int got = 0;
  int mon_exp;
  int q[$];
  logic [7:0] hist [0:D+1];

  pe_seq_ctrl #(.ROW_LEN(R), .PIPE_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .filt_cfg(filt_cfg),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pe_en(pe_en), .pe_ifmap(pe_ifmap), .pe_filt(pe_filt), .pe_psum(pe_psum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done)
`ifdef PE_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // PE model: pixel history advancing on pe_en; output for a window lags its last pixel by D pe_en edges.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= D + 1; i++) hist[i] <= 8'd0;
    end else if (pe_en) begin
      for (int i = D + 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= pe_ifmap;
    end
  end
  assign pe_psum = 14'(pe_filt[11:8]) * 14'(hist[D+1]) + 14'(pe_filt[7:4]) * 14'(hist[D]) + 14'(pe_filt[3:0]) * 14'(hist[D-1]);

  // Scoreboard: every accepted result is popped and compared in order.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      checks++;
      got++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL res_unexpected got=%0d expected none", res_data);
      end else begin
        mon_exp = q.pop_front();
        if (res_data !== 14'(mon_exp)) begin
          errors++;
          $display("FAIL res_data got=%0d expected=%0d", res_data, mon_exp);
        end
      end
    end
  end

  function automatic logic [7:0] pix(input int i, input bit hi);
    return hi ? 8'(255 - 3 * i) : 8'(i + 1);
  endfunction

  task automatic run_row(input logic [31:0] gap_mask, input int stall_len, input int start_at,
                         input int abort_at, input bit hi, output int ndone);
    int cyc, idx, stall_left, post;
    bit stall_used;
    for (int i = 2; i < R; i++)
      q.push_back(int'(filt_cfg[11:8]) * pix(i-2, hi) + int'(filt_cfg[7:4]) * pix(i-1, hi) + int'(filt_cfg[3:0]) * pix(i, hi));
    got = 0;
    ndone = 0;
    cyc = 0;
    idx = 0;
    stall_left = 0;
    stall_used = 0;
    post = 0;
    @(posedge clk); #1;
    start = 1'b1;
    res_ready = 1'b1;
    pix_valid = 1'b0;
    while (cyc < 300) begin
      @(negedge clk);
      if (pix_valid && pix_ready) idx++;
      if (done) begin
        ndone++;
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL done_busy busy=%b expected 1", busy);
        end
      end
      if (stall_left > 0 && !res_ready) begin
        checks++;
        if (pix_ready !== 1'b0 || pe_en !== 1'b0 || res_data !== 14'(q[0]) || res_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold pix_ready=%b pe_en=%b res_valid=%b res_data=%0d expected 0 0 1 %0d",
                   pix_ready, pe_en, res_valid, res_data, q[0]);
        end
      end
      if (cyc < 32 && gap_mask[cyc] && idx < R) begin
        checks++;
        if (pe_en !== 1'b0) begin
          errors++;
          $display("FAIL bubble_pe_en cyc=%0d pe_en=%b expected 0", cyc, pe_en);
        end
      end
      if (abort_at > 0 && idx == abort_at) break;
      if (ndone > 0) post++;
      if (post > 3) break;
      @(posedge clk); #1;
      cyc++;
      start = (cyc == start_at);
      if (stall_left > 0) stall_left--;
      if (stall_len > 0 && !stall_used && res_valid) begin
        stall_used = 1;
        stall_left = stall_len;
      end
      res_ready = (stall_left == 0);
      pix_valid = idx < R && !(cyc < 32 && gap_mask[cyc]);
      pix_data = pix(idx, hi);
    end
    start = 1'b0;
    pix_valid = 1'b0;
    res_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, res_valid, pe_en, pix_ready} !== 5'b0 || pe_filt !== 12'd0 || res_data !== 14'd0 || pe_ifmap !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b rv=%b pe_en=%b pr=%b filt=%h rd=%0d ifmap=%0d expected all 0",
               busy, done, res_valid, pe_en, pix_ready, pe_filt, res_data, pe_ifmap);
    end
`ifdef PE_SEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt got=%0d expected 0", stall_cnt);
    end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    pix_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release res_valid=%b busy=%b expected 0 0", res_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    int nd;
    filt_cfg = 12'h321;
    run_row(32'h0, 0, -1, 0, 0, nd);
    checks++;
    if (nd !== 1 || got !== R - 2 || q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_row done=%0d results=%0d left=%0d expected 1 %0d 0", nd, got, q.size(), R - 2);
    end
    checks++;
    if (pe_filt !== 12'h321 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_filt_idle pe_filt=%h busy=%b expected 321 0", pe_filt, busy);
    end
  endtask

  task automatic test_bubbles();
    int nd;
    run_row(32'hAAAAAAAA, 0, -1, 0, 0, nd);
    checks++;
    if (nd !== 1 || got !== R - 2 || q.size() !== 0) begin
      errors++;
      $display("FAIL bubble_row done=%0d results=%0d left=%0d expected 1 %0d 0", nd, got, q.size(), R - 2);
    end
  endtask

  task automatic test_backpressure();
    int nd;
    run_row(32'h0, 5, -1, 0, 0, nd);
    checks++;
    if (nd !== 1 || got !== R - 2 || q.size() !== 0) begin
      errors++;
      $display("FAIL bp_row done=%0d results=%0d left=%0d expected 1 %0d 0", nd, got, q.size(), R - 2);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    run_row(32'h0, 0, -1, 4, 0, nd);
    @(posedge clk); #1;
    rst_n = 1'b0;
    pix_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || pe_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrow_reset busy=%b res_valid=%b pe_en=%b done=%b expected 0 0 0 0", busy, res_valid, pe_en, done);
    end
    pix_valid = 1'b0;
    q.delete();
    run_row(32'h0, 0, -1, 0, 0, nd);
    checks++;
    if (nd !== 1 || got !== R - 2 || q.size() !== 0) begin
      errors++;
      $display("FAIL midrow_rerun done=%0d results=%0d left=%0d expected 1 %0d 0", nd, got, q.size(), R - 2);
    end
  endtask

  task automatic test_start_in_run();
    int nd;
    filt_cfg = 12'hF5A;
    run_row(32'h0, 0, 5, 0, 1, nd);
    checks++;
    if (nd !== 1 || got !== R - 2 || q.size() !== 0) begin
      errors++;
      $display("FAIL start_ignored done=%0d results=%0d left=%0d expected 1 %0d 0", nd, got, q.size(), R - 2);
    end
    checks++;
    if (pe_filt !== 12'hF5A) begin
      errors++;
      $display("FAIL filt_reload pe_filt=%h expected f5a", pe_filt);
    end
  endtask

  task automatic test_stall_cnt();
    int nd;
    filt_cfg = 12'h321;
    run_row(32'h000000A8, 5, -1, 0, 0, nd);
    checks++;
    if (nd !== 1 || got !== R - 2 || q.size() !== 0) begin
      errors++;
      $display("FAIL stall_row done=%0d results=%0d left=%0d expected 1 %0d 0", nd, got, q.size(), R - 2);
    end
`ifdef PE_SEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd8) begin
      errors++;
      $display("FAIL stall_cnt got=%0d expected 8", stall_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_backpressure();
    test_reset_mid();
    test_start_in_run();
    test_stall_cnt();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pe_seq_ctrl.md
PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 SHALL have parameter ROW_LEN, default 32, giving pixels per ifmap row (legal range 3..1023).
REQ-002 SHALL have parameter PIPE_LAT, default 1, giving the number of pe_en edges from pixel shift-in to the matching valid pe_psum.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: begin one row; sampled only in IDLE.
REQ-006 SHALL have port filt_cfg, input, 12 bits: three 4-bit weights, w0=[3:0], w1=[7:4], w2=[11:8].
REQ-007 SHALL have ports pix_valid (input, 1 bit), pix_ready (output, 1 bit) and pix_data (input, 8 bits): ifmap pixel stream.
REQ-008 SHALL have ports pe_en (output, 1 bit), pe_ifmap (output, 8 bits) and pe_filt (output, 12 bits): PE drive.
REQ-009 SHALL have port pe_psum, input, 14 bits: PE partial sum.
REQ-010 SHALL have ports res_valid (output, 1 bit), res_ready (input, 1 bit) and res_data (output, 14 bits): result stream.
REQ-011 SHALL have ports busy (output, 1 bit: not IDLE) and done (output, 1 bit: one-cycle pulse at row completion).

Function
REQ-012 SHALL implement the FSM IDLE->LOAD on start; LOAD->RUN after 1 cycle; RUN->DRAIN once ROW_LEN pixels are accepted; DRAIN->DONE once all ROW_LEN-2 results are accepted; DONE->IDLE after 1 cycle.
REQ-013 SHALL latch filt_cfg into pe_filt in LOAD and hold it until the next LOAD.
REQ-014 SHALL, in RUN, assert pix_ready = !stall, where stall = tag_out && res_valid && !res_ready.
REQ-015 SHALL accept a pixel on pix_valid && pix_ready, drive it on pe_ifmap and assert pe_en in the same cycle.
REQ-016 SHALL drive pe_en = 0 when pix_valid is low in RUN, creating a bubble in which the PE pipeline holds.
REQ-017 SHALL, in DRAIN, assert pe_en with pe_ifmap = 0 whenever !stall, until the tag pipeline is empty; no pixel SHALL be consumed in DRAIN.
REQ-018 SHALL keep a tag shift register of depth 2+PIPE_LAT that advances only on pe_en and enters 1 for pixel index >= 2 (0-based), else 0; tag_out is its last stage.
REQ-019 SHALL, when tag_out && pe_en && (!res_valid || res_ready), load res_data from pe_psum and set res_valid.
REQ-020 SHALL hold res_valid and res_data stable until res_ready; res_valid SHALL clear on acceptance when no new capture occurs.
REQ-021 SHALL produce exactly ROW_LEN-2 results per row, in pixel order; the pixel counter SHALL saturate at ROW_LEN.
REQ-022 SHALL ignore start outside IDLE.
REQ-023 SHALL pass pe_psum through without arithmetic; the 14-bit width covers the maximum 3*255*15 = 11475.
REQ-024 SHALL assert done together with busy high for the single DONE cycle only.

Reset
REQ-025 SHALL, on rst_n = 0 at a clock edge, enter IDLE and clear all outputs, counters and tags to 0, including in mid-row.
REQ-026 SHALL capture no result in the cycle after reset release.

Configuration
REQ-027 SHALL, with PE_SEQ_STALL_CNT_EN defined, add output stall_cnt[15:0] that counts cycles with busy && (stall || (RUN && !pix_valid)), saturates at 16'hFFFF and clears on LOAD and reset.
REQ-028 SHALL, without PE_SEQ_STALL_CNT_EN, omit the stall_cnt port and its logic entirely.

Verification
REQ-029 SHALL cover: ROW_LEN=8, filt_cfg=12'h321, pixels 1..8 back-to-back, res_ready=1 -> res_data 10,16,22,28,34,40, then a done pulse.
REQ-030 SHALL cover: same row with pix_valid toggling every other cycle -> identical results; pe_en low during the bubbles.
REQ-031 SHALL cover: res_ready=0 for 5 cycles after the first result -> pix_ready=0 and pe_en=0 while stalled; res_data holds 10; no result lost.
REQ-032 SHALL cover: rst_n=0 asserted after 4 pixels -> next cycle busy=0, res_valid=0, pe_en=0; a new start then yields the correct full row.
REQ-033 SHALL cover: start pulsed during RUN -> ignored; exactly 6 results and a single done.
REQ-034 SHALL cover: PE_SEQ_STALL_CNT_EN defined, 5-cycle res_ready stall plus 3 pix_valid gaps -> stall_cnt = 8.
